// File: rtl/rv32_ex_muldiv.sv
// ---------------------------------------------------------------------------
// rv32_ex_muldiv
// Iterative RV32M multiply/divide unit sitting behind the ID/EX register.
// Multiplies with a 32-step shift-add and divides with a 32-step restoring
// algorithm, both on operand magnitudes, then applies the sign fix-up.
// Divide-by-zero and signed overflow bypass the iterations.
//
// Ports
//   clk, rst_n      rising-edge clock, asynchronous active-low reset
//   flush           abort the current operation (no result strobe)
//   code_in         instruction word held in ID/EX
//   rs1_in, rs2_in  source operands held in ID/EX
//   busy            hold request for ID/EX and upstream stages
//   result          rd value, meaningful while result_valid is high
//   result_valid    one-cycle strobe marking result as final
//   dbg_state       current FSM state (0 IDLE, 1 CALC, 2 DONE)
//
// Handshake: busy is a hold, not a ready. While busy=1 the ID/EX register
// must keep code_in/rs1_in/rs2_in stable; the register advances on the edge
// that ends the result_valid cycle. There is no back-pressure on the result.
// ---------------------------------------------------------------------------
module rv32_ex_muldiv #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic [31:0]     code_in,
    input  logic [XLEN-1:0] rs1_in,
    input  logic [XLEN-1:0] rs2_in,
    output logic            busy,
    output logic [XLEN-1:0] result,
    output logic            result_valid,
    output logic [1:0]      dbg_state
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] a_q, a_d;        // multiplicand magnitude
    logic [31:0] b_q, b_d;        // divisor magnitude
    logic [63:0] prod_q, prod_d;  // mul: {partial hi, multiplier}; div: [31:0] dividend -> quotient
    logic [31:0] rem_q, rem_d;    // partial remainder
    logic        qneg_q, qneg_d;  // negate product / quotient
    logic        rneg_q, rneg_d;  // negate remainder
    logic [31:0] result_q, result_d;

    // ---------------- decode of the held instruction ----------------
    logic        is_m;
    logic [2:0]  funct3;
    logic        is_div;
    logic        s1, s2;
    logic        neg1, neg2;
    logic [31:0] mag1, mag2;
    logic        div_zero, div_ovf;
    logic        unused_code;

    assign is_m   = (code_in[6:0] == 7'b0110011) && (code_in[31:25] == 7'b0000001);
    assign funct3 = code_in[14:12];
    assign is_div = funct3[2];
    assign unused_code = ^code_in[24:7] ^ ^code_in[11:7];

    always_comb begin
        s1 = 1'b0;
        s2 = 1'b0;
        case (funct3)
            3'b000, 3'b001, 3'b100, 3'b110: begin s1 = 1'b1; s2 = 1'b1; end
            3'b010:                         begin s1 = 1'b1; s2 = 1'b0; end
            default:                        begin s1 = 1'b0; s2 = 1'b0; end
        endcase
    end

    assign neg1 = s1 & rs1_in[31];
    assign neg2 = s2 & rs2_in[31];
    assign mag1 = neg1 ? (~rs1_in + 32'd1) : rs1_in;
    assign mag2 = neg2 ? (~rs2_in + 32'd1) : rs2_in;

    assign div_zero = is_div && (rs2_in == 32'd0);
    assign div_ovf  = is_div && !funct3[0] && (rs1_in == 32'h8000_0000) &&
                      (rs2_in == 32'hFFFF_FFFF);

    // ---------------- one iteration of each datapath ----------------
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] div_shift, div_diff;
    logic        div_ok;
    logic [31:0] div_rem_next, div_quo_next;

    // Shift-add: add multiplicand into the high half when the current
    // multiplier bit is set, then shift the whole 64-bit accumulator right.
    assign mul_sum  = {1'b0, prod_q[63:32]} + (prod_q[0] ? {1'b0, a_q} : 33'd0);
    assign mul_next = {mul_sum, prod_q[31:1]};

    // Restoring divide: bring in the next dividend bit, trial-subtract, and
    // keep the difference only if it did not go negative.
    assign div_shift    = {rem_q, prod_q[31]};
    assign div_diff     = div_shift - {1'b0, b_q};
    assign div_ok       = ~div_diff[32];
    assign div_rem_next = div_ok ? div_diff[31:0] : div_shift[31:0];
    assign div_quo_next = {prod_q[30:0], div_ok};

    // Sign fix-up applied to the values produced by the last iteration.
    logic [63:0] prod_fix;
    logic [31:0] quo_fix, rem_fix, final_res;

    assign prod_fix = qneg_q ? (~mul_next + 64'd1) : mul_next;
    assign quo_fix  = qneg_q ? (~div_quo_next + 32'd1) : div_quo_next;
    assign rem_fix  = rneg_q ? (~div_rem_next + 32'd1) : div_rem_next;

    always_comb begin
        case (op_q)
            3'b000:                 final_res = prod_fix[31:0];
            3'b001, 3'b010, 3'b011: final_res = prod_fix[63:32];
            3'b100, 3'b101:         final_res = quo_fix;
            default:                final_res = rem_fix;
        endcase
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        prod_d   = prod_q;
        rem_d    = rem_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        result_d = result_q;

        case (state_q)
            IDLE: begin
                if (is_m && !flush) begin
                    op_d   = funct3;
                    cnt_d  = 5'd0;
                    a_d    = mag1;
                    b_d    = mag2;
                    rem_d  = 32'd0;
                    qneg_d = neg1 ^ neg2;
                    rneg_d = neg1;
                    prod_d = is_div ? {32'd0, mag1} : {32'd0, mag2};
                    if (div_zero) begin
                        state_d  = DONE;
                        result_d = funct3[1] ? rs1_in : 32'hFFFF_FFFF;
                    end else if (div_ovf) begin
                        state_d  = DONE;
                        result_d = funct3[1] ? 32'd0 : 32'h8000_0000;
                    end else begin
                        state_d  = CALC;
                    end
                end
            end
            CALC: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                    if (op_q[2]) begin
                        prod_d = {32'd0, div_quo_next};
                        rem_d  = div_rem_next;
                    end else begin
                        prod_d = mul_next;
                    end
                    if (cnt_q == 5'd31) begin
                        state_d  = DONE;
                        result_d = final_res;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= 5'd0;
            op_q     <= 3'd0;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            prod_q   <= 64'd0;
            rem_q    <= 32'd0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            result_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            prod_q   <= prod_d;
            rem_q    <= rem_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            result_q <= result_d;
        end
    end

    // busy is combinational in IDLE so ID/EX never slips past an M op.
    assign busy = ((state_q == IDLE) && is_m && !flush) ||
                  ((state_q == CALC) && !flush);
    assign result_valid = (state_q == DONE) && !flush;
    assign result       = result_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_rv32_ex_muldiv.sv
module tb_rv32_ex_muldiv;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic [31:0] code_in;
  logic [31:0] rs1_in;
  logic [31:0] rs2_in;
  logic        busy;
  logic [31:0] result;
  logic        result_valid;
  logic [1:0]  dbg_state;

  int tests_run;
  int tests_failed;

  logic [31:0] exp_q[$];

  localparam logic [31:0] NOP_ADD = {7'b0000000, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011};

  rv32_ex_muldiv #(.XLEN(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .code_in      (code_in),
    .rs1_in       (rs1_in),
    .rs2_in       (rs2_in),
    .busy         (busy),
    .result       (result),
    .result_valid (result_valid),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  function automatic logic [31:0] mk_m(input logic [2:0] f3);
    mk_m = {7'b0000001, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model straight from the RV32M definitions.
  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] p;
    int sa;
    int sb;
    logic ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    model = 32'd0;
    case (f3)
      3'b000: begin p = {32'd0, a} * {32'd0, b}; model = p[31:0]; end
      3'b001: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; model = p[63:32]; end
      3'b010: begin p = {{32{a[31]}}, a} * {32'd0, b}; model = p[63:32]; end
      3'b011: begin p = {32'd0, a} * {32'd0, b}; model = p[63:32]; end
      3'b100: model = (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb);
      3'b101: model = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: model = (b == 0) ? a : ovf ? 32'd0 : 32'(sa % sb);
      default: model = (b == 0) ? a : a % b;
    endcase
  endfunction

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (rst_n && result_valid) begin
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL unexpected_valid: result_valid=1 result=0x%08h with nothing expected", result);
      end else begin
        check("scoreboard_result", result, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver ----------------
  // Called #1 after a rising edge with the FSM in IDLE.
  task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] lit, input int exp_lat);
    int busy_cnt;
    int lat;
    logic got;
    logic [31:0] got_res;
    code_in = mk_m(f3);
    rs1_in  = a;
    rs2_in  = b;
    exp_q.push_back(model(f3, a, b));
    check({name, "_model"}, model(f3, a, b), lit);
    busy_cnt = 0;
    lat      = -1;
    got      = 1'b0;
    got_res  = 32'd0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (result_valid) begin
        got     = 1'b1;
        got_res = result;
        lat     = i;
      end
      @(posedge clk);
      #1;
    end
    if (!got) begin
      tests_run++;
      tests_failed++;
      $display("FAIL %s_timeout: no result_valid within 60 cycles", name);
      void'(exp_q.pop_front());
    end else begin
      check({name, "_result"}, got_res, lit);
      check({name, "_latency"}, 32'(lat), 32'(exp_lat));
      check({name, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_lat));
    end
    code_in = NOP_ADD;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n   = 1'b0;
    flush   = 1'b0;
    code_in = NOP_ADD;
    rs1_in  = 32'd0;
    rs2_in  = 32'd0;
    #3;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_result", result, 32'd0);
    check("reset_valid", {31'd0, result_valid}, 32'd0);
    check("reset_state", {30'd0, dbg_state}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Main function, full-latency paths.
    run_op("mul_7_m3",   3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
    run_op("mulh_m1",    3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33);
    run_op("mulhsu_m1",  3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
    run_op("mulhu_max",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    run_op("mulhu_2p32", 3'b011, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001, 33);
    run_op("div_m7_2",   3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33);
    run_op("rem_m7_2",   3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33);
    run_op("divu_7_2",   3'b101, 32'h0000_0007, 32'h0000_0002, 32'h0000_0003, 33);
    run_op("div_min_2",  3'b100, 32'h8000_0000, 32'h0000_0002, 32'hC000_0000, 33);
    run_op("rem_7_m2",   3'b110, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 33);
    run_op("remu_100_7", 3'b111, 32'd100,       32'd7,         32'h0000_0002, 33);
    run_op("divu_max_1", 3'b101, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 33);

    // Special cases: one-cycle path.
    run_op("div_5_0",    3'b100, 32'd5,         32'd0,         32'hFFFF_FFFF, 1);
    run_op("divu_5_0",   3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 1);
    run_op("remu_9_0",   3'b111, 32'd9,         32'd0,         32'h0000_0009, 1);
    run_op("rem_ovf",    3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);
    run_op("div_ovf",    3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);

    // Flush at CALC iteration 10 (cycle 11).
    code_in = mk_m(3'b000);
    rs1_in  = 32'd1234;
    rs2_in  = 32'd5678;
    for (int i = 0; i < 11; i++) begin
      @(posedge clk);
      #1;
    end
    flush = 1'b1;
    @(negedge clk);
    check("flush_state_calc", {30'd0, dbg_state}, 32'd1);
    check("flush_busy_drop", {31'd0, busy}, 32'd0);
    check("flush_no_valid", {31'd0, result_valid}, 32'd0);
    @(posedge clk);
    #1;
    flush   = 1'b0;
    code_in = NOP_ADD;
    @(negedge clk);
    check("flush_to_idle", {30'd0, dbg_state}, 32'd0);
    check("flush_idle_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    run_op("mul_3_4", 3'b000, 32'd3, 32'd4, 32'h0000_000C, 33);

    // Result holds outside DONE; ADD never raises busy.
    code_in = NOP_ADD;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("add_busy", {31'd0, busy}, 32'd0);
      check("add_state", {30'd0, dbg_state}, 32'd0);
      check("hold_result", result, 32'h0000_000C);
      @(posedge clk);
      #1;
    end

    // Asynchronous reset mid-CALC.
    code_in = mk_m(3'b000);
    rs1_in  = 32'h0001_2345;
    rs2_in  = 32'd3;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
    end
    #1;
    check("pre_reset_calc", {30'd0, dbg_state}, 32'd1);
    rst_n   = 1'b0;
    code_in = NOP_ADD;
    #1;
    check("areset_busy", {31'd0, busy}, 32'd0);
    check("areset_result", result, 32'd0);
    check("areset_valid", {31'd0, result_valid}, 32'd0);
    check("areset_state", {30'd0, dbg_state}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_op("mulhsu_after_rst", 3'b010, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 33);

    @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/rv32_ex_muldiv.md
# rv32_ex_muldiv

Iterative RV32M multiply/divide unit in the Execute stage, directly downstream of the ID/EX pipeline register. It decodes the held instruction word, runs a 32-iteration shift-add multiply or restoring divide on the RS1/RS2 operands, and drives `busy` back to the ID/EX register and upstream stages so the instruction stays frozen while it computes. It delivers a one-cycle `result_valid` with the 32-bit result for writeback muxing.

## Interface
- `XLEN`, 32, operand/result width; only 32 supported.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  pipeline flush; aborts any operation in progress.
- `code_in`  in  32  instruction word from the ID/EX register (`code_out`).
- `rs1_in`  in  32  RS1 operand from the ID/EX register.
- `rs2_in`  in  32  RS2 operand from the ID/EX register.
- `busy`  out  1  hold request to the ID/EX register and upstream stages.
- `result`  out  32  computed rd value; valid only while `result_valid`=1.
- `result_valid`  out  1  one-cycle strobe: `result` is final.

## Operation
- M-instruction detect (`is_m`): opcode[6:0]=0110011 and funct7=0000001. funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- FSM states: IDLE, CALC, DONE.
- IDLE: if `is_m` & ~`flush`, latch the operand magnitudes, sign-fix flags and op, clear the iteration counter, and go to CALC. The special cases below go straight to DONE with the result preloaded.
- CALC: one iteration per cycle; 5-bit counter 0..31; leave to DONE after the iteration with counter=31.
- DONE: `result_valid`=1, `busy`=0; go to IDLE unconditionally.
- Signedness: MUL/MULH/DIV/REM use both operands signed. MULHSU uses rs1 signed and rs2 unsigned. MULHU/DIVU/REMU use both unsigned.
- Signed operands are converted to absolute value before iterating; the core datapath is unsigned only.
- Multiply: shift-add into a 64-bit product. Negate the product if the operand signs differ. MUL returns product[31:0]; MULH/MULHSU/MULHU return product[63:32].
- Divide: restoring algorithm with a 33-bit partial remainder. The quotient is negated if the signs differ (signed ops). The remainder takes the sign of the dividend.
- Divide by zero (rs2=0, detected in IDLE): quotient = 0xFFFFFFFF; remainder = rs1.
- Signed overflow (DIV/REM, rs1=0x80000000, rs2=0xFFFFFFFF): quotient = 0x80000000; remainder = 0.
- `busy` = (IDLE & `is_m` & ~`flush`) | CALC. It is combinational in IDLE so the ID/EX register never advances past an M instruction.
- The rd=x0 case is not special; the writeback stage gates it.
- `flush` in CALC: go to IDLE next edge; no `result_valid`; `busy` drops combinationally in that cycle.
- `flush` in DONE: `result_valid` is forced low in that cycle.
- The hazard unit must not raise the ID/EX `stall` while `busy`=1.

## Timing
- Reset values: state IDLE, `busy`=0 (unless `is_m` presented), `result`=0, `result_valid`=0, counter=0.
- Normal latency: M instruction first present in IDLE at cycle 0, CALC for cycles 1–32, DONE at cycle 33. `busy` is high for cycles 0–32, which is 33 cycles.
- Special-case latency: IDLE at cycle 0, DONE at cycle 1; `busy` is high for 1 cycle.
- The ID/EX register loads the next instruction on the edge that ends DONE. Back-to-back M instructions restart from IDLE with no extra bubble.
- `result` holds its last value outside DONE.
- Reset mid-CALC returns all state to the reset values asynchronously.
- Non-M instruction: `busy`=0 and the FSM stays in IDLE.

## Test plan
- MUL 7 × −3 (rs1=0x00000007, rs2=0xFFFFFFFD) -> `busy` high 33 cycles, then one-cycle `result_valid`, `result`=0xFFFFFFEB.
- MULH/MULHSU/MULHU with rs1=0xFFFFFFFF, rs2=0xFFFFFFFF -> 0x00000000, 0xFFFFFFFF, 0xFFFFFFFE respectively.
- DIV −7/2, REM −7/2, DIVU 7/2 -> 0xFFFFFFFD, 0xFFFFFFFF, 0x00000003.
- DIV 5/0 -> result 0xFFFFFFFF, `busy` high 1 cycle. REM 0x80000000/−1 -> 0x00000000 at DONE in cycle 1.
- `flush` at CALC iteration 10 -> `busy` drops the same cycle, no `result_valid`, FSM in IDLE. The following MUL 3×4 returns 0x0000000C at full latency.
- ADD instruction (funct7=0000000) -> `busy` stays 0. Async reset asserted mid-CALC -> all outputs return to their reset values immediately.
